crc32_stream_engine: RTL and testbench
======================================

// Module: crc32_stream_engine
// PURPOSE
//  Frame-level, parameterised CRC-32 engine for the MAC TX (FCS generate) and RX (FCS check) paths.
//  Accepts DATA_BYTES-wide beats with a byte-keep mask and valid/ready handshake.
//  Folds any tail length in one cycle using slice tables computed at elaboration from POLY (no memory files).
//  Emits a registered per-frame result (CRC, residue match, byte count) through a valid/ready output.
// PARAMETERS
//  DATA_BYTES   8             beat width in bytes (1..16); lane 0 = first byte on the wire
//  POLY         32'hEDB88320  reflected generator polynomial (LSB-first processing)
//  INIT         32'hFFFFFFFF  CRC register value at frame start
//  XOR_OUT      32'hFFFFFFFF  XOR applied to the register to form out_crc
//  RESIDUE      32'hDEBB20E3  register value (before XOR_OUT) after data+FCS of a good frame
//  CNT_WIDTH    16            width of out_bytes; counter saturates at all-ones
// PORTS
//  clk        in   1             clock
//  rst        in   1             asynchronous reset, active-high
//  in_valid   in   1             input beat valid
//  in_ready   out  1             engine can accept a beat
//  in_data    in   8*DATA_BYTES  beat data, byte i = in_data[8i+:8]
//  in_keep    in   DATA_BYTES    byte enables; all-ones except on the last beat
//  in_last    in   1             final beat of the frame
//  in_abort   in   1             discard the current frame (sampled with in_valid&&in_ready)
//  out_valid  out  1             frame result available
//  out_ready  in   1             result consumer ready
//  out_crc    out  32            final register ^ XOR_OUT; out_crc[7:0] is transmitted first
//  out_match  out  1             final register == RESIDUE (RX check)
//  out_bytes  out  CNT_WIDTH     bytes accepted in the frame (saturating)
//  out_err    out  1             keep protocol violation seen in the frame
// BEHAVIOUR
//  Reset: state IDLE, crc_reg=INIT, count=0, err=0. All out_* = 0; in_ready = 1.
//  Beat accepted when in_valid && in_ready. in_ready = (state != DONE) || out_ready.
//  States:
//   IDLE  -> BUSY on an accepted non-last beat.
//   IDLE  -> DONE on an accepted last beat.
//   BUSY  -> DONE on an accepted last beat.
//   BUSY  -> IDLE on an accepted abort.
//   DONE  holds the result until out_valid && out_ready, then goes to IDLE.
//   DONE with out_ready high also accepts a beat in the same cycle; that beat starts a new frame (zero-bubble).
//  Update: n = number of keep bits set. crc_reg <= fold(crc_reg, first n bytes) per slice-by-n LSB-first.
//   The byte count adds n.
//   n=0 on a non-last beat: beat consumed, no state change.
//   n=0 on a last beat: frame closes with the current crc_reg.
//  Keep rule: in_keep must be contiguous from bit 0 (e.g. 8'b0000_0111).
//   Non-contiguous keep, or keep != all-ones on a non-last beat, sets err.
//   The beat is still folded using the contiguous low run only.
//  Result: out_valid rises the cycle after the last beat is accepted (latency 1).
//   out_* stay stable while out_valid && !out_ready.
//   crc_reg and count reload to INIT/0 for the next frame.
//  Abort: discards crc, count and err; no result produced. Abort with last in the same beat: abort wins.
//  Abort in IDLE is a no-op.
//  Mid-frame reset: the frame is lost, no result is produced, and state returns to reset values immediately.
// TESTING
//  DATA_BYTES=8; beats "12345678" keep 8'hFF, then "9" keep 8'h01 last
//   -> out_crc=32'hCBF43926, out_bytes=9, out_err=0.
//  Same 9 bytes followed by FCS bytes 26 39 F4 CB (LSB first)
//   -> out_match=1, out_bytes=13. Flip one data bit -> out_match=0.
//  Back-to-back frames with out_ready=1
//   -> in_ready stays 1, two results on consecutive out_valid pulses, each correct.
//  out_ready=0 for 5 cycles after a result
//   -> out_* held stable, in_ready=0, no beat lost.
//  Abort after 3 beats, then a fresh "123456789" frame
//   -> only one result, 32'hCBF43926.
//  Keep 8'h05 on a last beat
//   -> out_err=1, CRC covers byte 0 only. Assert rst mid-frame -> out_valid=0, next frame correct.

Source files
------------

// File: rtl/crc32_stream_engine.sv
// crc32_stream_engine
// Frame-level CRC-32 engine for MAC TX (FCS generate) and RX (FCS check).
// Takes DATA_BYTES-wide beats with a contiguous byte-keep mask and folds the
// whole beat into the CRC register in one cycle. Emits one registered result
// per frame (CRC, residue match, byte count, keep error).
//
// Handshake: a transfer happens on a rising clk edge where valid && ready are
// both high. The producer holds valid and its payload stable until that edge,
// and ready never depends combinationally on the same interface's valid.

module crc32_stream_engine #(
  parameter int          DATA_BYTES = 8,
  parameter logic [31:0] POLY       = 32'hEDB88320,
  parameter logic [31:0] INIT       = 32'hFFFFFFFF,
  parameter logic [31:0] XOR_OUT    = 32'hFFFFFFFF,
  parameter logic [31:0] RESIDUE    = 32'hDEBB20E3,
  parameter int          CNT_WIDTH  = 16
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [8*DATA_BYTES-1:0]   in_data,
  input  logic [DATA_BYTES-1:0]     in_keep,
  input  logic                      in_last,
  input  logic                      in_abort,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [31:0]               out_crc,
  output logic                      out_match,
  output logic [CNT_WIDTH-1:0]      out_bytes,
  output logic                      out_err,
  output logic [1:0]                dbg_state
);

  localparam int NW = $clog2(DATA_BYTES + 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t                 state, state_next;
  logic [31:0]            crc_reg;
  logic [CNT_WIDTH-1:0]   byte_cnt;
  logic                   err_reg;
  logic [31:0]            res_crc;
  logic                   res_match;
  logic [CNT_WIDTH-1:0]   res_bytes;
  logic                   res_err;

  logic                   accept;
  logic [NW-1:0]          lane_cnt;
  logic [DATA_BYTES-1:0]  low_mask;
  logic                   run;
  logic                   beat_err;
  logic [31:0]            folded;
  logic [CNT_WIDTH:0]     cnt_sum;
  logic [CNT_WIDTH-1:0]   cnt_next;

  // One byte through the reflected LFSR, LSB first. Unrolled across lanes
  // below, this flattens into the same XOR network a slice table would give,
  // derived from POLY at elaboration.
  function automatic logic [31:0] crc_byte(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c ^ {24'd0, b};
    for (int k = 0; k < 8; k++) begin
      r = r[0] ? ((r >> 1) ^ POLY) : (r >> 1);
    end
    return r;
  endfunction

  assign accept = in_valid && in_ready;

  // Length of the contiguous keep run starting at lane 0; only that run is folded.
  always_comb begin
    lane_cnt = '0;
    low_mask = '0;
    run      = 1'b1;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (run && in_keep[i]) begin
        low_mask[i] = 1'b1;
        lane_cnt    = NW'(i + 1);
      end else begin
        run = 1'b0;
      end
    end
  end

  // Keep violation: holes in the mask, or a short beat that is not the last.
  assign beat_err = (in_keep != low_mask) ||
                    (!in_last && (in_keep != {DATA_BYTES{1'b1}}));

  // Fold the kept lanes into the running CRC in a single cycle.
  always_comb begin
    folded = crc_reg;
    for (int i = 0; i < DATA_BYTES; i++) begin
      if (low_mask[i]) folded = crc_byte(folded, in_data[8*i +: 8]);
    end
  end

  // Saturating byte count including this beat.
  always_comb begin
    cnt_sum  = {1'b0, byte_cnt} + (CNT_WIDTH + 1)'(lane_cnt);
    cnt_next = cnt_sum[CNT_WIDTH] ? {CNT_WIDTH{1'b1}} : cnt_sum[CNT_WIDTH-1:0];
  end

  // FSM state register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  // FSM next state; in DONE with out_ready the result drains and a new beat may start a frame.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (accept && !in_abort) begin
          if (in_last)                state_next = DONE;
          else if (lane_cnt != '0)    state_next = BUSY;
        end
      end
      BUSY: begin
        if (accept) begin
          if (in_abort)               state_next = IDLE;
          else if (in_last)           state_next = DONE;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_next = IDLE;
          if (accept && !in_abort) begin
            if (in_last)              state_next = DONE;
            else if (lane_cnt != '0)  state_next = BUSY;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // FSM outputs: result valid while in DONE; input stalls only on an unconsumed result.
  always_comb begin
    out_valid = (state == DONE);
    in_ready  = (state != DONE) || out_ready;
    dbg_state = state;
  end

  // Running frame state and the registered per-frame result.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      crc_reg   <= INIT;
      byte_cnt  <= '0;
      err_reg   <= 1'b0;
      res_crc   <= '0;
      res_match <= 1'b0;
      res_bytes <= '0;
      res_err   <= 1'b0;
    end else if (accept) begin
      if (in_abort) begin
        if (state == BUSY) begin
          crc_reg  <= INIT;
          byte_cnt <= '0;
          err_reg  <= 1'b0;
        end
      end else if (in_last) begin
        res_crc   <= folded ^ XOR_OUT;
        res_match <= (folded == RESIDUE);
        res_bytes <= cnt_next;
        res_err   <= err_reg | beat_err;
        crc_reg   <= INIT;
        byte_cnt  <= '0;
        err_reg   <= 1'b0;
      end else begin
        crc_reg  <= folded;
        byte_cnt <= cnt_next;
        err_reg  <= err_reg | beat_err;
      end
    end
  end

  assign out_crc   = res_crc;
  assign out_match = res_match;
  assign out_bytes = res_bytes;
  assign out_err   = res_err;

endmodule

// File: tb/tb_crc32_stream_engine.sv
// Directed bench for crc32_stream_engine with DATA_BYTES=8.
// Beats are driven just after a rising edge; outputs are sampled #1 after the edge.

module tb_crc32_stream_engine;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_data;
  logic [7:0]  in_keep;
  logic        in_last;
  logic        in_abort;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_crc;
  logic        out_match;
  logic [15:0] out_bytes;
  logic        out_err;
  logic [1:0]  dbg_state;

  int vectors     = 0;
  int miscompares = 0;

  // "12345678" with '1' in lane 0
  localparam logic [63:0] D_1TO8 = 64'h3837363534333231;
  // '9' then FCS bytes 26 39 F4 CB
  localparam logic [63:0] D_9FCS = 64'h000000CBF4392639;

  crc32_stream_engine #(
    .DATA_BYTES(8),
    .POLY(32'hEDB88320),
    .INIT(32'hFFFFFFFF),
    .XOR_OUT(32'hFFFFFFFF),
    .RESIDUE(32'hDEBB20E3),
    .CNT_WIDTH(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_keep(in_keep),
    .in_last(in_last),
    .in_abort(in_abort),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_crc(out_crc),
    .out_match(out_match),
    .out_bytes(out_bytes),
    .out_err(out_err),
    .dbg_state(dbg_state)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Present one beat and hold it until accepted (bounded).
  task automatic drive(input logic [63:0] d, input logic [7:0] k, input logic l, input logic a);
    int guard;
    in_data  = d;
    in_keep  = k;
    in_last  = l;
    in_abort = a;
    in_valid = 1'b1;
    guard = 0;
    while (!in_ready && guard < 50) begin
      @(negedge clk);
      guard++;
    end
    if (!in_ready) chk("drive_ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    in_abort = 1'b0;
  endtask

  // Wait (bounded) for a result and compare all its fields.
  task automatic expect_result(input string tag, input logic [31:0] crc, input logic m,
                               input logic [15:0] nbytes, input logic e);
    int guard;
    guard = 0;
    while (!out_valid && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    chk({tag, "_valid"}, {31'd0, out_valid}, 32'd1);
    chk({tag, "_crc"},   out_crc, crc);
    chk({tag, "_match"}, {31'd0, out_match}, {31'd0, m});
    chk({tag, "_bytes"}, {16'd0, out_bytes}, {16'd0, nbytes});
    chk({tag, "_err"},   {31'd0, out_err}, {31'd0, e});
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0;
    in_data = '0;
    in_keep = '0;
    in_last = 1'b0;
    in_abort = 1'b0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;

    // reset state
    chk("rst_out_valid", {31'd0, out_valid}, 32'd0);
    chk("rst_in_ready",  {31'd0, in_ready}, 32'd1);
    chk("rst_out_crc",   out_crc, 32'd0);
    chk("rst_out_bytes", {16'd0, out_bytes}, 32'd0);
    chk("rst_out_match", {31'd0, out_match}, 32'd0);
    chk("rst_out_err",   {31'd0, out_err}, 32'd0);
    chk("rst_state",     {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;

    // "123456789" check value
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(64'h39, 8'h01, 1'b1, 1'b0);
    expect_result("basic", 32'hCBF43926, 1'b0, 16'd9, 1'b0);

    // data + FCS leaves the residue
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(D_9FCS, 8'h1F, 1'b1, 1'b0);
    expect_result("fcs_good", 32'h2144DF1C, 1'b1, 16'd13, 1'b0);

    // one flipped data bit breaks the residue
    drive(64'h3837363534333230, 8'hFF, 1'b0, 1'b0);
    drive(D_9FCS, 8'h1F, 1'b1, 1'b0);
    chk("fcs_bad_valid", {31'd0, out_valid}, 32'd1);
    chk("fcs_bad_match", {31'd0, out_match}, 32'd0);
    chk("fcs_bad_bytes", {16'd0, out_bytes}, 32'd13);

    // back-to-back frames, zero bubble
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    chk("b2b_ready0", {31'd0, in_ready}, 32'd1);
    drive(64'h39, 8'h01, 1'b1, 1'b0);
    expect_result("b2b_a", 32'hCBF43926, 1'b0, 16'd9, 1'b0);
    chk("b2b_ready1", {31'd0, in_ready}, 32'd1);
    drive(64'h00, 8'h01, 1'b1, 1'b0);
    expect_result("b2b_b", 32'hD202EF8D, 1'b0, 16'd1, 1'b0);
    @(posedge clk); #1;
    chk("b2b_drained", {31'd0, out_valid}, 32'd0);

    // consumer stall for 5 cycles with the next beat waiting
    out_ready = 1'b0;
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(64'h39, 8'h01, 1'b1, 1'b0);
    in_data  = 64'h31;
    in_keep  = 8'h01;
    in_last  = 1'b1;
    in_valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      chk("stall_valid", {31'd0, out_valid}, 32'd1);
      chk("stall_crc",   out_crc, 32'hCBF43926);
      chk("stall_bytes", {16'd0, out_bytes}, 32'd9);
      chk("stall_ready", {31'd0, in_ready}, 32'd0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_last  = 1'b0;
    expect_result("stall_next", 32'h83DCEFB7, 1'b0, 16'd1, 1'b0);

    // abort (with last set) after 3 beats, then a fresh frame
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(D_1TO8, 8'h01, 1'b1, 1'b1);
    chk("abort_no_result", {31'd0, out_valid}, 32'd0);
    chk("abort_state", {30'd0, dbg_state}, 32'd0);
    drive(D_1TO8, 8'hFF, 1'b0, 1'b1);
    chk("abort_idle_noop", {30'd0, dbg_state}, 32'd0);
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(64'h39, 8'h01, 1'b1, 1'b0);
    expect_result("after_abort", 32'hCBF43926, 1'b0, 16'd9, 1'b0);

    // non-contiguous keep on a last beat folds byte 0 only
    drive(D_1TO8, 8'h05, 1'b1, 1'b0);
    expect_result("keep05", 32'h83DCEFB7, 1'b0, 16'd1, 1'b1);

    // short non-last beat flags err but still folds its bytes
    drive(64'h34333231, 8'h0F, 1'b0, 1'b0);
    drive(64'h0000003938373635, 8'h1F, 1'b1, 1'b0);
    expect_result("short_mid", 32'hCBF43926, 1'b0, 16'd9, 1'b1);

    // empty last beat closes the frame with the current register
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(64'h39, 8'h01, 1'b0, 1'b0);
    drive(64'h0, 8'h00, 1'b1, 1'b0);
    expect_result("empty_last", 32'hCBF43926, 1'b0, 16'd9, 1'b1);

    // reset mid-frame
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    chk("midrst_valid", {31'd0, out_valid}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    chk("midrst_state", {30'd0, dbg_state}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    drive(D_1TO8, 8'hFF, 1'b0, 1'b0);
    drive(64'h39, 8'h01, 1'b1, 1'b0);
    expect_result("after_rst", 32'hCBF43926, 1'b0, 16'd9, 1'b0);

    @(posedge clk); #1;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
